// File: rtl/secure_key_pkg.sv
// Shared types and power-on contents for the secure key vault.
// Entry 1 holds the comms key; entry 0 starts invalid.
package secure_key_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_RSP,
      ST_ZERO
   } vault_state_e;

   localparam int KEY_W     = 512;
   localparam int KEY_DEPTH = 6;
   localparam int KEY_IDX_W = 3;

   localparam logic [127:0] COMMS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   localparam logic [KEY_W-1:0] KEY_INIT [KEY_DEPTH] = '{
      {KEY_W{1'b0}},
      {384'h0, COMMS_KEY},
      {16{32'h2222_2222}},
      {16{32'h3333_3333}},
      {16{32'h4444_4444}},
      {16{32'h5555_5555}}
   };

   localparam logic [KEY_DEPTH-1:0] INIT_VALID = 6'b111110;
   localparam logic [KEY_DEPTH-1:0] INIT_LOCK  = 6'b000010;

   // Entries beyond the table come up empty, invalid and unlocked.
   function automatic logic [KEY_W-1:0] key_init(input int i);
      logic [KEY_IDX_W-1:0] idx;
      idx = KEY_IDX_W'(i);
      if (i < 0 || i >= KEY_DEPTH) return '0;
      return KEY_INIT[idx];
   endfunction

   function automatic logic init_valid(input int i);
      logic [KEY_IDX_W-1:0] idx;
      idx = KEY_IDX_W'(i);
      if (i < 0 || i >= KEY_DEPTH) return 1'b0;
      return INIT_VALID[idx];
   endfunction

   function automatic logic init_lock(input int i);
      logic [KEY_IDX_W-1:0] idx;
      idx = KEY_IDX_W'(i);
      if (i < 0 || i >= KEY_DEPTH) return 1'b0;
      return INIT_LOCK[idx];
   endfunction

endpackage

// File: rtl/secure_key_vault_if.sv
// Request/response channel between the security controller and the key vault.
interface secure_key_vault_if #(
   parameter int WIDTH    = 512,
   parameter int WR_WIDTH = 256,
   parameter int ADDR_W   = 3
);
   logic                req_valid;
   logic                req_ready;
   logic                req_write;
   logic [ADDR_W-1:0]   req_addr;
   logic [WR_WIDTH-1:0] req_wdata;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [WIDTH-1:0]    rsp_data;
   logic                rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/key_write_stager.sv
// Collects write beats into a full-width staging word; commit_data already
// includes the beat being presented so the final beat commits in its own cycle.
module key_write_stager #(
   parameter int WIDTH    = 512,
   parameter int WR_WIDTH = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                beat_en,
   input  logic [WR_WIDTH-1:0] wdata,
   output logic                last,
   output logic [WIDTH-1:0]    commit_data
);
   localparam int BEATS = WIDTH / WR_WIDTH;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] stage_q;

   assign last = (cnt_q == CNT_W'(BEATS - 1));

   always_comb begin
      commit_data = stage_q;
      commit_data[cnt_q*WR_WIDTH +: WR_WIDTH] = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         stage_q <= '0;
      end else if (clear) begin
         cnt_q   <= '0;
         stage_q <= '0;
      end else if (beat_en) begin
         stage_q[cnt_q*WR_WIDTH +: WR_WIDTH] <= wdata;
         cnt_q <= last ? '0 : cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/secure_key_vault.sv
// Key/secret store: atomic multi-beat writes, sticky per-entry locks,
// and a one-entry-per-cycle zeroize walk.
module secure_key_vault
   import secure_key_pkg::*;
#(
   parameter int WIDTH    = 512,
   parameter int WR_WIDTH = 256,
   parameter int DEPTH    = 6,
   localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   secure_key_vault_if.slave bus,
   input  logic              lock_valid,
   input  logic [ADDR_W-1:0] lock_addr,
   input  logic              zeroize,
   output logic              busy
);
   vault_state_e      state_q, state_d;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [DEPTH-1:0]  valid_q, lock_q;
   logic [ADDR_W-1:0] addr_q, zidx_q, commit_addr;
   logic [WIDTH-1:0]  rsp_data_q, commit_data;
   logic              rsp_err_q;
   logic              req_fire, beat_en, last_beat, commit, commit_ok, lock_hit, rd_ok;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
   endfunction

   assign bus.req_ready = (state_q == ST_IDLE) || (state_q == ST_WRITE);
   assign bus.rsp_valid = (state_q == ST_RSP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign busy          = (state_q == ST_ZERO);

   assign req_fire    = bus.req_valid && bus.req_ready;
   assign beat_en     = !zeroize && req_fire && ((state_q == ST_WRITE) || bus.req_write);
   assign commit      = beat_en && last_beat;
   assign commit_addr = (state_q == ST_WRITE) ? addr_q : bus.req_addr;
   // A lock landing on the same edge as the commit must win.
   assign lock_hit    = lock_valid && (lock_addr == commit_addr);
   assign commit_ok   = in_range(commit_addr) && !lock_q[commit_addr] && !lock_hit;
   assign rd_ok       = in_range(bus.req_addr) && valid_q[bus.req_addr];

   key_write_stager #(
      .WIDTH    (WIDTH),
      .WR_WIDTH (WR_WIDTH)
   ) u_stager (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (zeroize),
      .beat_en     (beat_en),
      .wdata       (bus.req_wdata),
      .last        (last_beat),
      .commit_data (commit_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (zeroize) begin
         state_d = ST_ZERO;
      end else begin
         case (state_q)
            ST_IDLE:  if (req_fire) state_d = (!bus.req_write || last_beat) ? ST_RSP : ST_WRITE;
            ST_WRITE: if (commit) state_d = ST_RSP;
            ST_RSP:   if (bus.rsp_ready) state_d = ST_IDLE;
            ST_ZERO:  if (zidx_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i]     <= WIDTH'(key_init(i));
            valid_q[i] <= init_valid(i);
            lock_q[i]  <= init_lock(i);
         end
         addr_q     <= '0;
         zidx_q     <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else if (zeroize) begin
         zidx_q     <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         if (state_q == ST_ZERO) begin
            mem[zidx_q]     <= '0;
            valid_q[zidx_q] <= 1'b0;
            lock_q[zidx_q]  <= 1'b0;
            zidx_q          <= zidx_q + 1'b1;
         end else if (lock_valid && in_range(lock_addr)) begin
            lock_q[lock_addr] <= 1'b1;
         end

         if (state_q == ST_IDLE && req_fire && !bus.req_write) begin
            rsp_data_q <= rd_ok ? mem[bus.req_addr] : '0;
            rsp_err_q  <= !rd_ok;
         end
         if (state_q == ST_IDLE && req_fire && bus.req_write) addr_q <= bus.req_addr;

         if (commit) begin
            if (commit_ok) begin
               mem[commit_addr]     <= commit_data;
               valid_q[commit_addr] <= 1'b1;
            end
            rsp_data_q <= '0;
            rsp_err_q  <= !commit_ok;
         end

         if (state_q == ST_RSP && bus.rsp_ready) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_secure_key_vault.sv
// Directed bench for secure_key_vault: reads, bursts, locks, zeroize and reset.
module tb_secure_key_vault;
   localparam logic [511:0] K1 = {384'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
   localparam logic [511:0] K2 = {16{32'h2222_2222}};
   localparam logic [511:0] K3 = {16{32'h3333_3333}};
   localparam logic [511:0] K5 = {16{32'h5555_5555}};
   localparam logic [255:0] BA = {64{4'hA}};
   localparam logic [255:0] BB = {64{4'hB}};
   localparam logic [255:0] BC = {64{4'hC}};
   localparam logic [255:0] BD = {64{4'hD}};

   logic       clk;
   logic       rst_n;
   logic       lock_valid;
   logic [2:0] lock_addr;
   logic       zeroize;
   logic       busy;
   int         n_checks;
   int         n_errors;
   int         busy_cnt;

   secure_key_vault_if #(.WIDTH(512), .WR_WIDTH(256), .ADDR_W(3)) bus ();

   secure_key_vault #(.WIDTH(512), .WR_WIDTH(256), .DEPTH(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .lock_valid (lock_valid),
      .lock_addr  (lock_addr),
      .zeroize    (zeroize),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request beat and hold it until accepted.
   task automatic send(input logic wr, input logic [2:0] addr, input logic [255:0] d);
      int w;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = d;
      w = 0;
      while (!bus.req_ready && w < 20) begin
         step();
         w++;
      end
      if (!bus.req_ready) check("req_ready_timeout", 512'(bus.req_ready), 512'd1);
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic take_rsp(input string tag, input logic [511:0] exp_data, input logic exp_err);
      int w;
      w = 0;
      while (!bus.rsp_valid && w < 20) begin
         step();
         w++;
      end
      check({tag, "_valid"}, 512'(bus.rsp_valid), 512'd1);
      check({tag, "_data"}, bus.rsp_data, exp_data);
      check({tag, "_err"}, 512'(bus.rsp_err), 512'(exp_err));
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [2:0] addr, input logic [511:0] exp_data,
                           input logic exp_err);
      send(1'b0, addr, '0);
      take_rsp(tag, exp_data, exp_err);
   endtask

   task automatic write2(input string tag, input logic [2:0] addr, input logic [255:0] b0,
                         input logic [255:0] b1, input logic exp_err);
      send(1'b1, addr, b0);
      send(1'b1, addr, b1);
      take_rsp(tag, '0, exp_err);
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      rst_n         = 1'b0;
      lock_valid    = 1'b0;
      lock_addr     = '0;
      zeroize       = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;
      step();
      step();
      check("rst_req_ready", 512'(bus.req_ready), 512'd1);
      check("rst_rsp_valid", 512'(bus.rsp_valid), 512'd0);
      check("rst_rsp_data", bus.rsp_data, '0);
      check("rst_rsp_err", 512'(bus.rsp_err), 512'd0);
      check("rst_busy", 512'(busy), 512'd0);
      rst_n = 1'b1;
      step();

      // Comms key read, response held while rsp_ready stays low
      send(1'b0, 3'd1, '0);
      check("rd1_latency", 512'(bus.rsp_valid), 512'd1);
      check("rd1_ready_low", 512'(bus.req_ready), 512'd0);
      for (int i = 0; i < 3; i++) begin
         check("rd1_hold_valid", 512'(bus.rsp_valid), 512'd1);
         check("rd1_hold_data", bus.rsp_data, K1);
         step();
      end
      take_rsp("rd1", K1, 1'b0);
      check("rd1_clr_valid", 512'(bus.rsp_valid), 512'd0);
      check("rd1_clr_data", bus.rsp_data, '0);

      read_chk("rd0_invalid", 3'd0, '0, 1'b1);
      read_chk("rd7_range", 3'd7, '0, 1'b1);

      // Spaced two-beat write to entry 2
      read_chk("rd2_old", 3'd2, K2, 1'b0);
      send(1'b1, 3'd2, BA);
      step();
      step();
      check("wr2_gap_ready", 512'(bus.req_ready), 512'd1);
      check("wr2_gap_valid", 512'(bus.rsp_valid), 512'd0);
      send(1'b0, 3'd5, BB);
      take_rsp("wr2", '0, 1'b0);
      read_chk("rd2_new", 3'd2, {BB, BA}, 1'b0);

      write2("wr1_locked", 3'd1, BC, BD, 1'b1);
      read_chk("rd1_unchanged", 3'd1, K1, 1'b0);
      write2("wr7_range", 3'd7, BC, BD, 1'b1);

      // Lock arriving with the final beat wins
      send(1'b1, 3'd3, BA);
      lock_valid = 1'b1;
      lock_addr  = 3'd3;
      send(1'b1, 3'd3, BB);
      lock_valid = 1'b0;
      take_rsp("wr3_lockrace", '0, 1'b1);
      read_chk("rd3_locked", 3'd3, K3, 1'b0);
      write2("wr3_sticky", 3'd3, BC, BD, 1'b1);

      // Zeroize arriving with beat 0 of a write to entry 4
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 3'd4;
      bus.req_wdata = BA;
      zeroize       = 1'b1;
      step();
      zeroize       = 1'b0;
      bus.req_valid = 1'b0;
      check("zero_ready", 512'(bus.req_ready), 512'd0);
      busy_cnt = 0;
      while (busy && busy_cnt < 20) begin
         if (bus.rsp_valid) check("zero_no_rsp", 512'(bus.rsp_valid), 512'd0);
         busy_cnt++;
         step();
      end
      check("zero_busy_cycles", 512'(busy_cnt), 512'd6);
      check("zero_rsp_valid", 512'(bus.rsp_valid), 512'd0);
      for (int a = 0; a < 6; a++) read_chk("rd_zeroed", 3'(a), '0, 1'b1);
      write2("wr1_unlocked", 3'd1, BC, BD, 1'b0);
      read_chk("rd1_written", 3'd1, {BD, BC}, 1'b0);

      // Asynchronous reset while a response is pending
      send(1'b0, 3'd5, '0);
      step();
      check("rsp_pending", 512'(bus.rsp_valid), 512'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_rsp_valid", 512'(bus.rsp_valid), 512'd0);
      check("arst_rsp_err", 512'(bus.rsp_err), 512'd0);
      check("arst_req_ready", 512'(bus.req_ready), 512'd1);
      step();
      step();
      rst_n = 1'b1;
      step();
      read_chk("rd5_reload", 3'd5, K5, 1'b0);
      read_chk("rd2_reload", 3'd2, K2, 1'b0);
      write2("wr1_relocked", 3'd1, BC, BD, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end
endmodule

// File: doc/secure_key_vault.md
Name: secure_key_vault

Overview:
Parametrised key/secret store, the successor to the fixed six-entry secure memory. It holds DEPTH entries of WIDTH bits, loaded from package constants on reset. Wide entries are written as multi-beat bursts of WR_WIDTH and committed atomically. Each entry has a sticky write-lock and a valid bit, and a zeroize sequence wipes every entry. A single valid/ready request channel and a single valid/ready response channel connect it to the security controller and crypto engines.

Parameters:
WIDTH, 512, entry width in bits
WR_WIDTH, 256, write beat width; WIDTH % WR_WIDTH == 0; BEATS = WIDTH/WR_WIDTH
DEPTH, 6, number of entries; ADDR_W = $clog2(DEPTH), minimum 1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = write burst start, 0 = read; sampled only in IDLE
req_addr  in  ADDR_W  entry index; sampled only in IDLE
req_wdata  in  WR_WIDTH  write beat data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_data  out  WIDTH  read data; 0 for writes and errors
rsp_err  out  1  request failed
lock_valid  in  1  single-cycle pulse: lock entry lock_addr
lock_addr  in  ADDR_W  entry to lock
zeroize  in  1  single-cycle pulse: wipe store
busy  out  1  high while zeroize is in progress

Behaviour:
- Reset values:
  - state IDLE; req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
  - entry[i]=KEY_INIT[i]; valid=INIT_VALID; lock=INIT_LOCK; beat counter 0; staging buffer 0.
- FSM states: IDLE, WRITE, RSP, ZERO.
- IDLE: req_ready=1.
  - Accepted read -> RSP next cycle (1-cycle latency).
    - Normal read: rsp_data=entry, rsp_err=0.
    - addr>=DEPTH or valid=0: rsp_data=0, rsp_err=1.
  - Accepted write -> req_wdata is beat 0, placed in staging bits [0 +: WR_WIDTH]; latch addr.
    - BEATS==1: go directly to commit.
    - Otherwise -> WRITE.
- WRITE: req_ready=1. Each accepted beat k goes to staging [k*WR_WIDTH +: WR_WIDTH]; req_write and req_addr are ignored.
  - On the last beat (k=BEATS-1), commit in that cycle's clock edge, then -> RSP with rsp_data=0.
  - Commit writes the entry and sets its valid bit only if addr<DEPTH and the entry is unlocked; rsp_err=0.
  - If addr>=DEPTH or the entry is locked at commit time, the entry is unchanged and rsp_err=1.
  - Beats may be spaced by idle cycles; there is no timeout.
- RSP: req_ready=0. Hold rsp_valid, rsp_data and rsp_err stable until rsp_ready; on handshake clear all three to 0 and return to IDLE.
- Lock:
  - lock_valid with lock_addr<DEPTH sets the lock bit at the next edge, in any state except ZERO.
  - Out-of-range lock_addr is ignored.
  - Lock is sticky until reset or zeroize; reads of locked entries succeed.
  - Lock and commit to the same entry in the same cycle: the lock wins and the commit fails with err.
- Zeroize:
  - Sampled in every state and has priority over all other events.
  - Next cycle: state ZERO, busy=1, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0. A pending response and any partial burst (staging, beat counter) are discarded.
  - ZERO clears one entry per cycle, index 0..DEPTH-1: data=0, valid=0, lock=0. After DEPTH cycles -> IDLE, busy=0.
  - A zeroize pulse during ZERO restarts the walk at index 0. lock_valid is ignored during ZERO.
- Reset mid-operation: asynchronous return to reset values, including KEY_INIT reload.
- Reads never observe half-written entries; staging is invisible until commit.

Decomposition:
- Package secure_key_pkg holds:
  - the state enum;
  - the KEY_INIT array of WIDTH-bit constants (entry 1 is the comms key, zero-extended);
  - INIT_VALID and INIT_LOCK DEPTH-bit masks, default valid=6'b111110, lock=6'b000010.
- Sub-module key_write_stager: beat counter, staging register and last-beat flag.

Test Plan:
- Reset, read addr 1 -> rsp one cycle after accept, rsp_err=0, rsp_data = zero-extended comms key; hold rsp_ready=0 for 3 cycles -> outputs stable.
- Read addr 0 (valid=0) and addr 7 (out of range) -> rsp_err=1, rsp_data=0 for both.
- Write addr 2, beats 256'hA.., 256'hB.. with 2 idle cycles between beats, then read addr 2 -> write rsp_err=0; read returns {B..,A..}; a read before commit returns the old value.
- Write addr 1 (locked at reset) -> rsp_err=1, entry unchanged. lock_valid addr 3 concurrent with the last beat of a write to 3 -> rsp_err=1.
- Zeroize during WRITE beat 0 of addr 4 -> busy high for exactly 6 cycles, no response. Then all reads give rsp_err=1, and a write to addr 1 succeeds because the lock was cleared.
- Assert rst_n low while in RSP -> rsp_valid=0 immediately; after release, addr 5 reads KEY_INIT[5].
